// File: rtl/cmp_result_tracker.sv
// cmp_result_tracker: samples the lower/equal/greater flags of an upstream
// magnitude comparator, keeps saturating per-class counters and the length
// of the current run of identical results, and drives a hysteretic alarm
// FSM that trips on a sustained run of "greater" results.
//
// Handshake: in_valid is a one-cycle strobe with no backpressure; the flags
// are sampled on the rising edge where in_valid=1, and every output reflects
// that sample one cycle later. A strobe whose flags are not one-hot is
// recorded in onehot_err and breaks the current run instead of being counted.
module cmp_result_tracker #(
    parameter int CNT_W     = 8,
    parameter int RUN_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             lower,
    input  logic             equal,
    input  logic             greater,
    output logic [CNT_W-1:0] lower_cnt,
    output logic [CNT_W-1:0] equal_cnt,
    output logic [CNT_W-1:0] greater_cnt,
    output logic [CNT_W-1:0] run_len,
    output logic             alarm,
    output logic             onehot_err,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_ALARM = 2'd2,
        S_BAD   = 2'd3
    } state_t;

    // Class of the most recent valid sample; C_NONE means no run in progress.
    typedef enum logic [1:0] {
        C_NONE = 2'd0,
        C_LOW  = 2'd1,
        C_EQ   = 2'd2,
        C_GT   = 2'd3
    } cls_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(RUN_LIMIT);

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d, cls_in;
    logic [CNT_W-1:0] lower_cnt_q, lower_cnt_d;
    logic [CNT_W-1:0] equal_cnt_q, equal_cnt_d;
    logic [CNT_W-1:0] greater_cnt_q, greater_cnt_d;
    logic [CNT_W-1:0] run_len_q, run_len_d;
    logic [CNT_W-1:0] quiet_q, quiet_d;
    logic             err_q, err_d;
    logic             alarm_q;
    logic             onehot;
    logic             sample_ok;
    logic             sample_bad;

    // Classify the incoming flags and split strobes into good / bad samples.
    always_comb begin
        onehot     = ({lower, equal, greater} == 3'b100) ||
                     ({lower, equal, greater} == 3'b010) ||
                     ({lower, equal, greater} == 3'b001);
        sample_ok  = in_valid && onehot;
        sample_bad = in_valid && !onehot;
        cls_in     = C_NONE;
        if (lower)        cls_in = C_LOW;
        else if (equal)   cls_in = C_EQ;
        else if (greater) cls_in = C_GT;
    end

    // Counters, run length, stored class and sticky error update.
    always_comb begin
        lower_cnt_d   = lower_cnt_q;
        equal_cnt_d   = equal_cnt_q;
        greater_cnt_d = greater_cnt_q;
        run_len_d     = run_len_q;
        cls_d         = cls_q;
        err_d         = err_q;
        if (sample_ok) begin
            if (lower   && lower_cnt_q   != CNT_MAX) lower_cnt_d   = lower_cnt_q + ONE;
            if (equal   && equal_cnt_q   != CNT_MAX) equal_cnt_d   = equal_cnt_q + ONE;
            if (greater && greater_cnt_q != CNT_MAX) greater_cnt_d = greater_cnt_q + ONE;
            if (cls_in == cls_q) begin
                if (run_len_q != CNT_MAX) run_len_d = run_len_q + ONE;
            end else begin
                run_len_d = ONE;
                cls_d     = cls_in;
            end
        end else if (sample_bad) begin
            err_d     = 1'b1;
            run_len_d = '0;
            cls_d     = C_NONE;
        end
    end

    // Alarm FSM next state; run_len_d is the run length including this sample.
    always_comb begin
        state_d = state_q;
        quiet_d = quiet_q;
        case (state_q)
            S_IDLE: begin
                if (sample_ok) begin
                    if (greater && run_len_d >= LIMIT) state_d = S_ALARM;
                    else                               state_d = S_TRACK;
                end
            end
            S_TRACK: begin
                if (sample_ok && greater && run_len_d >= LIMIT) state_d = S_ALARM;
            end
            S_ALARM: begin
                if (sample_bad) begin
                    quiet_d = '0;
                end else if (sample_ok) begin
                    if (greater) begin
                        quiet_d = '0;
                    end else if (quiet_q + ONE >= LIMIT) begin
                        state_d = S_TRACK;
                        quiet_d = '0;
                    end else begin
                        quiet_d = quiet_q + ONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                quiet_d = '0;
            end
        endcase
    end

    // State registers; reset has priority over clear, clear over samples.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_q       <= S_IDLE;
            cls_q         <= C_NONE;
            lower_cnt_q   <= '0;
            equal_cnt_q   <= '0;
            greater_cnt_q <= '0;
            run_len_q     <= '0;
            quiet_q       <= '0;
            err_q         <= 1'b0;
            alarm_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cls_q         <= cls_d;
            lower_cnt_q   <= lower_cnt_d;
            equal_cnt_q   <= equal_cnt_d;
            greater_cnt_q <= greater_cnt_d;
            run_len_q     <= run_len_d;
            quiet_q       <= quiet_d;
            err_q         <= err_d;
            alarm_q       <= (state_d == S_ALARM);
        end
    end

    assign lower_cnt   = lower_cnt_q;
    assign equal_cnt   = equal_cnt_q;
    assign greater_cnt = greater_cnt_q;
    assign run_len     = run_len_q;
    assign alarm       = alarm_q;
    assign onehot_err  = err_q;
    assign state       = state_q;

endmodule

// File: tb/tb_cmp_result_tracker.sv
// Directed bench for cmp_result_tracker (CNT_W=8, RUN_LIMIT=3).
// Inputs change on the falling edge; outputs are checked on the next
// falling edge, i.e. one cycle after the sample was taken.
module tb_cmp_result_tracker;

    localparam logic [2:0] F_L    = 3'b100;
    localparam logic [2:0] F_E    = 3'b010;
    localparam logic [2:0] F_G    = 3'b001;
    localparam logic [2:0] F_NONE = 3'b000;
    localparam logic [2:0] F_LG   = 3'b101;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       lower;
    logic       equal;
    logic       greater;
    logic [7:0] lower_cnt;
    logic [7:0] equal_cnt;
    logic [7:0] greater_cnt;
    logic [7:0] run_len;
    logic       alarm;
    logic       onehot_err;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    cmp_result_tracker #(.CNT_W(8), .RUN_LIMIT(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .lower       (lower),
        .equal       (equal),
        .greater     (greater),
        .lower_cnt   (lower_cnt),
        .equal_cnt   (equal_cnt),
        .greater_cnt (greater_cnt),
        .run_len     (run_len),
        .alarm       (alarm),
        .onehot_err  (onehot_err),
        .state       (state)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver: apply one cycle of inputs, return one cycle later (outputs updated).
    task automatic step_raw(input logic rstn_v, input logic clr_v,
                            input logic v, input logic [2:0] f);
        rst_n    = rstn_v;
        clear    = clr_v;
        in_valid = v;
        {lower, equal, greater} = f;
        @(negedge clk);
        rst_n    = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        {lower, equal, greater} = 3'b000;
    endtask

    task automatic step(input logic [2:0] f);
        step_raw(1'b1, 1'b0, 1'b1, f);
    endtask

    // Scoreboard: single comparison
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: full output vector
    task automatic chk_all(input string tag, input int lc, input int ec, input int gc,
                           input int rl, input int al, input int er, input int st);
        chk({tag, ".lower_cnt"},   32'(lower_cnt),   32'(lc));
        chk({tag, ".equal_cnt"},   32'(equal_cnt),   32'(ec));
        chk({tag, ".greater_cnt"}, 32'(greater_cnt), 32'(gc));
        chk({tag, ".run_len"},     32'(run_len),     32'(rl));
        chk({tag, ".alarm"},       32'(alarm),       32'(al));
        chk({tag, ".onehot_err"},  32'(onehot_err),  32'(er));
        chk({tag, ".state"},       32'(state),       32'(st));
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
        lower = 1'b0; equal = 1'b0; greater = 1'b0;
        @(negedge clk);

        // Reset then idle cycles
        step_raw(1'b0, 1'b0, 1'b0, F_NONE);
        step_raw(1'b0, 1'b0, 1'b0, F_NONE);
        repeat (5) step_raw(1'b1, 1'b0, 1'b0, F_NONE);
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);

        // G,G,G enters ALARM one cycle after the third sample
        step(F_G);
        chk_all("g1", 0, 0, 1, 1, 0, 0, 1);
        step(F_G);
        chk_all("g2", 0, 0, 2, 2, 0, 0, 1);
        step(F_G);
        chk_all("g3", 0, 0, 3, 3, 1, 0, 2);

        // in_valid=0 holds everything
        step_raw(1'b1, 1'b0, 1'b0, F_G);
        chk_all("hold", 0, 0, 3, 3, 1, 0, 2);

        // Hysteresis: L,E,G,L,E,L
        step(F_L);
        chk_all("h_l1", 1, 0, 3, 1, 1, 0, 2);
        step(F_E);
        chk_all("h_e1", 1, 1, 3, 1, 1, 0, 2);
        step(F_G);
        chk_all("h_g", 1, 1, 4, 1, 1, 0, 2);
        step(F_L);
        chk_all("h_l2", 2, 1, 4, 1, 1, 0, 2);
        step(F_E);
        chk_all("h_e2", 2, 2, 4, 1, 1, 0, 2);
        step(F_L);
        chk_all("h_l3", 3, 2, 4, 1, 0, 0, 1);

        // Invalid patterns in the middle of a greater run of 2
        step(F_G);
        step(F_G);
        chk_all("pre_inv", 3, 2, 6, 2, 0, 0, 1);
        step(F_NONE);
        chk_all("inv000", 3, 2, 6, 0, 0, 1, 1);
        step(F_LG);
        chk_all("inv101", 3, 2, 6, 0, 0, 1, 1);
        step(F_G);
        chk_all("post_inv", 3, 2, 7, 1, 0, 1, 1);

        // Clear, then saturation with 300 equal samples
        step_raw(1'b1, 1'b1, 1'b0, F_NONE);
        chk_all("clear", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) step(F_E);
        chk_all("sat", 0, 255, 0, 255, 0, 0, 1);

        // Clear together with a valid greater sample while in ALARM
        step_raw(1'b1, 1'b1, 1'b0, F_NONE);
        step(F_G);
        step(F_G);
        step(F_G);
        chk_all("pre_clr", 0, 0, 3, 3, 1, 0, 2);
        step_raw(1'b1, 1'b1, 1'b1, F_G);
        chk_all("clr_alarm", 0, 0, 0, 0, 0, 0, 0);
        step(F_G);
        chk_all("after_clr", 0, 0, 1, 1, 0, 0, 1);

        // Reset mid-run with a greater sample present
        step(F_G);
        step(F_G);
        chk_all("pre_rst", 0, 0, 3, 3, 1, 0, 2);
        step_raw(1'b0, 1'b0, 1'b1, F_G);
        chk_all("rst_mid", 0, 0, 0, 0, 0, 0, 0);
        step(F_G);
        chk_all("after_rst", 0, 0, 1, 1, 0, 0, 1);

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmp_result_tracker.md
# cmp_result_tracker

Sequential stage directly downstream of the 4-bit magnitude comparator. It samples the comparator's lower/equal/greater flags when the producer strobes a valid sample. It keeps saturating per-class occurrence counters and the run length of identical consecutive results. A three-state FSM raises a registered alarm after a sustained run of "greater" results and drops it again with hysteresis. Non-one-hot flag patterns are flagged as errors rather than counted.

## Interface
- CNT_W, 8, width of all counters and run_len (≥2)
- RUN_LIMIT, 3, consecutive greater samples to enter ALARM, and consecutive non-greater samples to leave it (1..2^CNT_W-1)

- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  synchronous, active-low reset
- clear  input  1  synchronous clear of counters, run, error and FSM (same effect as reset)
- in_valid  input  1  one-cycle strobe; flags are sampled this cycle
- lower  input  1  comparator flag, in1 < in2
- equal  input  1  comparator flag, in1 == in2
- greater  input  1  comparator flag, in1 > in2
- lower_cnt  output  CNT_W  count of valid lower samples, saturating
- equal_cnt  output  CNT_W  count of valid equal samples, saturating
- greater_cnt  output  CNT_W  count of valid greater samples, saturating
- run_len  output  CNT_W  length of the current run of identical valid results, saturating
- alarm  output  1  high while FSM is in ALARM
- onehot_err  output  1  sticky; set by any in_valid sample that is not exactly one-hot
- state  output  2  FSM state: 0 IDLE, 1 TRACK, 2 ALARM

## Operation
- A sample is valid when in_valid=1 and exactly one of lower/equal/greater is 1.
- On a valid sample:
  - Increment the matching counter; it holds at 2^CNT_W-1.
  - If the class equals the previous valid class, run_len increments (saturating).
  - Otherwise run_len becomes 1 and the stored class is updated.
- Invalid sample (in_valid=1, zero or ≥2 flags set):
  - onehot_err is set to 1 and stays set until reset or clear.
  - Counters are unchanged.
  - run_len goes to 0 and the stored class goes to "none", so the next valid sample starts a new run at 1.
  - FSM quiet counter goes to 0, and the FSM does not change state.
- in_valid=0: all state holds.
- FSM:
  - IDLE → TRACK on the first valid sample. If RUN_LIMIT=1 and that sample is greater, go directly IDLE → ALARM.
  - TRACK → ALARM on a valid greater sample that makes the greater run_len ≥ RUN_LIMIT.
  - ALARM: an internal quiet counter (CNT_W bits) counts consecutive valid lower/equal samples. A greater sample resets it to 0. When it reaches RUN_LIMIT, go ALARM → TRACK and reset it to 0.
  - State 3 is unreachable; if ever decoded, go to IDLE.
- Priority: rst_n=0 over clear over in_valid. A sample arriving in a clear cycle is dropped.

## Timing
- Everything is synchronous to the clk rising edge, and all outputs are registered.
- Reset (rst_n=0 at an edge) or clear=1:
  - All counters, run_len and onehot_err go to 0.
  - alarm goes to 0 and state goes to IDLE.
  - Internal class goes to "none" and the quiet counter to 0.
- Latency is 1 cycle: a sample in cycle N is reflected on all outputs in cycle N+1.
- alarm equals (state==ALARM) in the same cycle, and is never combinational from inputs.
- There is no backpressure; a sample can be accepted every cycle.
- Reset or clear mid-run discards the run. A greater sample immediately afterwards starts run_len at 1.

## Test plan
- Reset, then 5 idle cycles → all counters 0, run_len 0, alarm 0, state 0, onehot_err 0.
- Valid sequence G,G,G on consecutive cycles, RUN_LIMIT=3:
  - One cycle after the 3rd sample: greater_cnt=3, run_len=3, state=2, alarm=1.
  - One cycle after the 2nd sample: alarm is still 0.
- From ALARM, send L,E,G,L,E,L → alarm stays 1 through the G, and drops one cycle after the final L (3 consecutive non-greater). Final values: lower_cnt=3, equal_cnt=2, state=1.
- Invalid patterns 3'b000 and 3'b101 with in_valid=1, mid greater run of 2:
  - onehot_err=1 and run_len=0; counters unchanged.
  - A following G gives run_len=1 and no alarm.
- 300 valid equal samples with CNT_W=8 → equal_cnt=255 and run_len=255, both held; other counters 0.
- clear asserted together with a valid greater sample while in ALARM:
  - Next cycle: all outputs 0 and state IDLE; the sample is not counted.
  - Separately, rst_n=0 mid-run gives the same result.
